// File: rtl/fib_stream.sv
// Fibonacci-class sequence generator with runtime seeds, term index output and
// signed-overflow detection (halt or wrap) behind a start/ready/valid/done interface.
module fib_stream #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                        __clock,
  input  logic                        __reset,
  input  logic                        __start,
  input  logic signed [CNT_WIDTH-1:0] n,
  input  logic signed [WIDTH-1:0]     seed_a,
  input  logic signed [WIDTH-1:0]     seed_b,
  input  logic                        halt_on_ovf,
  input  logic                        __ready,
  output logic                        __valid,
  output logic                        __done,
  output logic signed [WIDTH-1:0]     __output_0,
  output logic signed [CNT_WIDTH-1:0] __output_1,
  output logic                        __overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 a_ovf;
  logic                 b_ovf;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] n_r;
  logic                 hof;

  logic [WIDTH-1:0]     sum;
  logic                 add_ovf;
  logic                 slot_free;
  logic                 n_pos;

  always_comb begin
    sum       = a + b;
    add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    slot_free = !__valid || __ready;
    n_pos     = !n[CNT_WIDTH-1] && (n != '0);
  end

  always_ff @(posedge __clock) begin
    if (!__reset) begin
      state      <= IDLE;
      __valid    <= 1'b0;
      __done     <= 1'b0;
      __overflow <= 1'b0;
      __output_0 <= '0;
      __output_1 <= '0;
      a          <= '0;
      b          <= '0;
      a_ovf      <= 1'b0;
      b_ovf      <= 1'b0;
      cnt        <= '0;
      n_r        <= '0;
      hof        <= 1'b0;
    end else if (__start) begin
      a          <= seed_a;
      b          <= seed_b;
      a_ovf      <= 1'b0;
      b_ovf      <= 1'b0;
      cnt        <= '0;
      n_r        <= n;
      hof        <= halt_on_ovf;
      __overflow <= 1'b0;
      __valid    <= 1'b0;
      __done     <= 1'b0;
      state      <= n_pos ? RUN : FIN;
    end else begin
      case (state)
        IDLE: begin
          __valid <= 1'b0;
          __done  <= 1'b0;
        end
        RUN: begin
          if (slot_free) begin
            // The done beat is presented on the same edge that enters FIN, so it
            // follows the last data beat without a bubble.
            if (cnt == n_r) begin
              __valid <= 1'b1;
              __done  <= 1'b1;
              state   <= FIN;
            end else if (a_ovf && hof) begin
              __overflow <= 1'b1;
              __valid    <= 1'b1;
              __done     <= 1'b1;
              state      <= FIN;
            end else begin
              __valid    <= 1'b1;
              __done     <= 1'b0;
              __output_0 <= a;
              __output_1 <= cnt;
              __overflow <= __overflow | a_ovf;
              a          <= b;
              b          <= sum;
              a_ovf      <= b_ovf;
              b_ovf      <= add_ovf | a_ovf | b_ovf;
              cnt        <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        FIN: begin
          // Entered straight from a start with n <= 0: the done beat is not yet up.
          if (!__valid) begin
            __valid <= 1'b1;
            __done  <= 1'b1;
          end else if (__ready) begin
            __valid <= 1'b0;
            __done  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fib_stream.md
# fib_stream

Parametrised Fibonacci-class sequence generator. It is the successor to the fixed 32-bit generator. Term and count widths are configurable, the two seeds are runtime inputs (Fibonacci, Lucas, any linear add-recurrence), a second output carries the term index, and signed overflow is detected with a selectable halt-or-wrap policy. It sits behind the standard start / ready / valid / done generator interface, so callers and benches drive it exactly like other generated generator blocks.

## Interface
- WIDTH, 32: signed term width (seeds, __output_0).
- CNT_WIDTH, 32: signed width of n and __output_1.
- __clock  in  1  sole clock, rising edge.
- __reset  in  1  synchronous, active-low reset. Low means reset.
- __start  in  1  high for one cycle to capture inputs and (re)start.
- n  in  CNT_WIDTH  signed number of terms to emit; sampled only when __start is high.
- seed_a  in  WIDTH  signed term 0; sampled on __start.
- seed_b  in  WIDTH  signed term 1; sampled on __start.
- halt_on_ovf  in  1  1 = stop at the first overflowed term; 0 = wrap and continue; sampled on __start.
- __ready  in  1  consumer accepts the current beat.
- __valid  out  1  current beat is valid.
- __done  out  1  current beat is the terminating beat and carries no data.
- __output_0  out  WIDTH  term value.
- __output_1  out  CNT_WIDTH  term index, starting at 0.
- __overflow  out  1  sticky; at least one term in this run overflowed.

## Operation
- **Recurrence:** t0 = seed_a, t1 = seed_b, t(k+2) = t(k+1) + t(k). Arithmetic is WIDTH-bit two's complement.
- **Internal registers:**
  - a holds the next term to emit and b the one after it; each carries an ovf tag.
  - cnt counts emitted terms; n_r holds the latched n; hof holds the latched halt_on_ovf.
- **Step:** emit a. Then a <= b; b <= a + b; b.ovf <= signed overflow of that add OR a.ovf OR b.ovf. Taint propagates, so a term is tagged if it overflowed itself or derives from an overflowed term. a.ovf <= b.ovf. cnt <= cnt + 1.
- **States:** IDLE, RUN, FIN.
  - IDLE: __valid = 0. Only __start leaves this state.
  - On __start: latch n, seeds and policy; clear __overflow; cnt = 0. Go to RUN if n > 0, otherwise go to FIN.
  - RUN, when the output slot is free:
    - If cnt == n_r, go to FIN.
    - Else if a.ovf and hof, set __overflow and go to FIN; this term is not emitted.
    - Else present a as a beat with __output_1 = cnt, OR a.ovf into __overflow, and step.
  - FIN: present the done beat (__valid = 1, __done = 1). __output_0 and __output_1 hold their last values. Once it is accepted, go to IDLE.
- **Output slot:** the slot is free when __valid is 0, or when __valid and __ready are both 1 at the edge (the beat is consumed).
- **Backpressure:** while __valid is 1 and __ready is 0, every output is held stable.
- **__ready while idle:** __ready is ignored when __valid is 0.
- **Restart:** __start mid-run, in any state, aborts the run. The pending unaccepted beat is dropped and the run restarts on the new inputs.
- **Reset precedence:** __reset low takes precedence over __start.

## Timing
- **Reset** (__reset low at an edge):
  - __valid = 0, __done = 0, __overflow = 0.
  - __output_0 = 0, __output_1 = 0.
  - State = IDLE.
- **Start latency:** with __start at edge E, the first beat (term 0 or the done beat) is valid after edge E+1.
- **Throughput:** with __ready held high, one beat per cycle and no bubbles between data beats. The done beat follows the last data beat on the next cycle.
- **Idle after done:** after the done beat is consumed, __valid and __done are 0 on the following cycle.
- **Sticky flag:** __overflow is held until the next __start or reset.
- **n ≤ 0:** exactly one done beat, with __overflow = 0.
- **Counter width:** cnt is CNT_WIDTH bits. For any n up to 2^(CNT_WIDTH-1) − 1 it cannot wrap, because the cnt == n_r check terminates the run first.

## Test plan
- **Basic sequence:** WIDTH = 32, seeds 0,1, n = 5, __ready high.
  - Data beats 0,1,1,2,3 with indices 0..4 on consecutive cycles.
  - Then one done beat; __overflow = 0.
- **Empty run:** n = 0, then n = −3.
  - Each produces a single done beat one cycle after start, with no data beats.
- **Backpressure:** n = 4, __ready pattern 1,0,0,1,0,1,1,1.
  - Sequence 0,1,1,2 then done, with no loss or duplication.
  - Outputs are stable on every cycle where __ready = 0.
- **Overflow, halt:** WIDTH = 8, seeds 0,1, n = 20, halt_on_ovf = 1.
  - 12 data beats: 0,1,1,2,3,5,8,13,21,34,55,89.
  - Then the done beat with __overflow = 1.
- **Overflow, wrap:** same stimulus with halt_on_ovf = 0.
  - Beat 12 = −112, and __overflow rises with that beat.
  - 20 data beats in total, then done with __overflow still 1.
- **Restart, then reset:**
  - During a run, assert __start with seeds 2,1 and n = 3: beats are 2,1,3 at indices 0..2, then done.
  - Next, assert __reset low together with __start: all outputs are 0 and no beat appears until a later __start.
